// File: rtl/bram_mem_responder_if.sv
// ---------------------------------------------------------------------------
// bram_mem_responder_if
// Request/response bundle between the system sequencer (master) and a memory
// responder (slave). Mirrors the PSRAM controller handshake so either backend
// can sit under the sequencer unchanged.
//
// Signals
//   i_cs           request select, active low
//   i_write        1 = write, 0 = read, sampled together with i_cs
//   i_address      byte address (responder may alias upper bits)
//   i_bank         bank select
//   i_dataToWrite  write data, sampled together with i_cs
//   o_dataRead     last read data, held until the next read completes
//   o_busy         1 = responder not accepting requests
//   o_dataReady    one-cycle pulse when read data is valid
//   o_state        responder state code (0 RESET, 1 IDLE, 2 WRITE, 3 READ)
// ---------------------------------------------------------------------------
interface bram_mem_responder_if;
   logic        i_cs;
   logic        i_write;
   logic [23:0] i_address;
   logic        i_bank;
   logic [7:0]  i_dataToWrite;
   logic [7:0]  o_dataRead;
   logic        o_busy;
   logic        o_dataReady;
   logic [2:0]  o_state;

   modport master (
      output i_cs, i_write, i_address, i_bank, i_dataToWrite,
      input  o_dataRead, o_busy, o_dataReady, o_state
   );

   modport slave (
      input  i_cs, i_write, i_address, i_bank, i_dataToWrite,
      output o_dataRead, o_busy, o_dataReady, o_state
   );
endinterface

// File: rtl/bram_mem_responder.sv
// ---------------------------------------------------------------------------
// bram_mem_responder
// Stands in for the PSRAM controller using on-chip block RAM. Requests are
// accepted in IDLE, held busy for a fixed LATENCY, then completed: writes
// update the array, reads register the array byte into o_dataRead and pulse
// o_dataReady for one clock.
//
// Ports
//   i_clkRAM   sole clock, everything on the rising edge
//   reset      synchronous, active-high; aborts any access in flight
//   bus        bram_mem_responder_if.slave request/response bundle
//
// Parameters
//   ADDR_BITS    low address bits used; array index is {i_bank, addr low bits}
//   LATENCY      clocks o_busy stays high per access (>= 2)
//   INIT_CYCLES  clocks spent in RESET after reset deasserts (>= 1)
// ---------------------------------------------------------------------------
module bram_mem_responder #(
   parameter int ADDR_BITS   = 12,
   parameter int LATENCY     = 4,
   parameter int INIT_CYCLES = 8
) (
   input  logic                  i_clkRAM,
   input  logic                  reset,
   bram_mem_responder_if.slave   bus
);

   localparam int IDX_BITS = ADDR_BITS + 1;
   localparam int DEPTH    = 1 << IDX_BITS;
   localparam int INIT_W   = $clog2(INIT_CYCLES + 1);
   localparam int LAT_W    = $clog2(LATENCY + 1);

   localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);
   localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(LATENCY - 1);

   typedef enum logic [2:0] {
      ST_RESET = 3'd0,
      ST_IDLE  = 3'd1,
      ST_WRITE = 3'd2,
      ST_READ  = 3'd3
   } state_t;

   state_t                state_q, state_d;
   logic [INIT_W-1:0]     init_cnt_q, init_cnt_d;
   logic [LAT_W-1:0]      lat_cnt_q, lat_cnt_d;
   logic [IDX_BITS-1:0]   req_index_q;
   logic [7:0]            req_data_q;
   logic                  ready_q;
   logic [7:0]            data_read_q;
   logic                  accept;
   logic                  access_done;
   logic                  mem_we;
   logic                  read_done;
   logic                  unused_addr_bits;

   logic [7:0] mem [DEPTH];

   // Address bits above ADDR_BITS-1 alias onto the same array location.
   assign unused_addr_bits = ^bus.i_address[23:ADDR_BITS];

   // Next-state logic. RESET counts out the init window, IDLE accepts a
   // request on i_cs low, and WRITE/READ run the latency counter. Requests
   // arriving while an access is in flight are simply not looked at.
   always_comb begin
      state_d     = state_q;
      init_cnt_d  = init_cnt_q;
      lat_cnt_d   = lat_cnt_q;
      accept      = 1'b0;
      access_done = 1'b0;
      case (state_q)
         ST_RESET: begin
            if (init_cnt_q == INIT_LAST) begin
               state_d    = ST_IDLE;
               init_cnt_d = '0;
            end else begin
               init_cnt_d = init_cnt_q + INIT_W'(1);
            end
         end
         ST_IDLE: begin
            if (!bus.i_cs) begin
               accept    = 1'b1;
               lat_cnt_d = '0;
               state_d   = bus.i_write ? ST_WRITE : ST_READ;
            end
         end
         ST_WRITE, ST_READ: begin
            if (lat_cnt_q == LAT_LAST) begin
               access_done = 1'b1;
               lat_cnt_d   = '0;
               state_d     = ST_IDLE;
            end else begin
               lat_cnt_d = lat_cnt_q + LAT_W'(1);
            end
         end
         default: begin
            state_d = ST_RESET;
         end
      endcase
   end

   assign mem_we    = access_done && (state_q == ST_WRITE);
   assign read_done = access_done && (state_q == ST_READ);

   // State, counters and the request latch. The read result is registered
   // straight out of the array so it maps onto the BRAM output register,
   // whose synchronous reset clears o_dataRead.
   always_ff @(posedge i_clkRAM) begin
      if (reset) begin
         state_q     <= ST_RESET;
         init_cnt_q  <= '0;
         lat_cnt_q   <= '0;
         req_index_q <= '0;
         req_data_q  <= '0;
         ready_q     <= 1'b0;
         data_read_q <= 8'h00;
      end else begin
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
         lat_cnt_q  <= lat_cnt_d;
         ready_q    <= read_done;
         if (accept) begin
            req_index_q <= {bus.i_bank, bus.i_address[ADDR_BITS-1:0]};
            req_data_q  <= bus.i_dataToWrite;
         end
         if (read_done) begin
            data_read_q <= mem[req_index_q];
         end
      end
   end

   // Array write port. Contents survive reset; a reset on the completion
   // edge suppresses the write so an aborted access leaves no trace.
   always_ff @(posedge i_clkRAM) begin
      if (mem_we && !reset) begin
         mem[req_index_q] <= req_data_q;
      end
   end

   assign bus.o_busy      = (state_q != ST_IDLE);
   assign bus.o_state     = state_q;
   assign bus.o_dataReady = ready_q;
   assign bus.o_dataRead  = data_read_q;

endmodule

// File: tb/tb_bram_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_bram_mem_responder
// Self-checking bench for bram_mem_responder (LATENCY 4, INIT_CYCLES 8).
// Inputs change 1 ns after the rising edge and outputs are sampled there too.
// Expected read data is pushed to a queue when a read is issued and popped
// when the responder signals o_dataReady.
// ---------------------------------------------------------------------------
module tb_bram_mem_responder;

   logic clk = 1'b0;
   logic rst;

   // 100 MHz clock
   always #5 clk = ~clk;

   bram_mem_responder_if bus ();

   bram_mem_responder #(
      .ADDR_BITS   (12),
      .LATENCY     (4),
      .INIT_CYCLES (8)
   ) dut (
      .i_clkRAM (clk),
      .reset    (rst),
      .bus      (bus)
   );

   int tests_run    = 0;
   int tests_failed = 0;

   logic [7:0] model_mem [0:8191];
   logic [7:0] expected_q [$];

   int         obs_busy_cycles;
   int         obs_ready_pulses;
   logic       obs_ready_at_fall;
   logic       obs_ready_next;
   logic [7:0] obs_data;

   // Array index as the responder sees it: bank on top, low 12 address bits.
   function automatic int idx(input logic bank, input logic [23:0] addr);
      logic [12:0] i;
      i = {bank, addr[11:0]};
      return int'(i);
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Issue one access from IDLE (i_cs low for one edge) and record what the
   // responder does until it drops o_busy, plus the sample one edge later.
   // With disturb set, a conflicting write request is held on the bus for
   // the whole busy window.
   task automatic applyStimulus(input logic wr, input logic bank,
                                input logic [23:0] addr, input logic [7:0] data,
                                input logic disturb);
      obs_busy_cycles   = 0;
      obs_ready_pulses  = 0;
      obs_ready_at_fall = 1'b0;
      obs_data          = 8'h00;
      bus.i_cs          = 1'b0;
      bus.i_write       = wr;
      bus.i_bank        = bank;
      bus.i_address     = addr;
      bus.i_dataToWrite = data;
      tick;
      if (disturb) begin
         bus.i_cs          = 1'b0;
         bus.i_write       = 1'b1;
         bus.i_bank        = 1'b0;
         bus.i_address     = 24'h000007;
         bus.i_dataToWrite = 8'h55;
      end else begin
         bus.i_cs = 1'b1;
      end
      while (bus.o_busy === 1'b1 && obs_busy_cycles <= 64) begin
         obs_busy_cycles++;
         if (bus.o_dataReady === 1'b1) obs_ready_pulses++;
         if (obs_busy_cycles <= 64) tick;
      end
      bus.i_cs = 1'b1;
      if (bus.o_dataReady === 1'b1) begin
         obs_ready_pulses++;
         obs_ready_at_fall = 1'b1;
         obs_data          = bus.o_dataRead;
      end
      tick;
      obs_ready_next = bus.o_dataReady;
   endtask

   task automatic test_reset;
      int  n;
      logic bad_busy;
      rst = 1'b1;
      bus.i_cs = 1'b1;
      repeat (3) tick;
      tests_run++;
      if (bus.o_state !== 3'd0 || bus.o_busy !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL reset_state: state=%0d busy=%b, expected state=0 busy=1", bus.o_state, bus.o_busy);
      end
      tests_run++;
      if (bus.o_dataReady !== 1'b0 || bus.o_dataRead !== 8'h00) begin
         tests_failed++;
         $display("[TB] FAIL reset_outputs: ready=%b data=%h, expected ready=0 data=00", bus.o_dataReady, bus.o_dataRead);
      end
      rst = 1'b0;
      n = 0;
      bad_busy = 1'b0;
      while (bus.o_state !== 3'd1 && n < 40) begin
         tick;
         n++;
         if (bus.o_state === 3'd0 && bus.o_busy !== 1'b1) bad_busy = 1'b1;
      end
      tests_run++;
      if (n !== 8) begin
         tests_failed++;
         $display("[TB] FAIL init_length: reached IDLE after %0d edges, expected 8", n);
      end
      tests_run++;
      if (bad_busy !== 1'b0 || bus.o_busy !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL init_busy: busy dropped early=%b, busy in IDLE=%b, expected 0 and 0", bad_busy, bus.o_busy);
      end
   endtask

   task automatic test_write_read;
      logic [7:0] exp;
      applyStimulus(1'b1, 1'b0, 24'h000002, 8'hCA, 1'b0);
      model_mem[idx(1'b0, 24'h000002)] = 8'hCA;
      tests_run++;
      if (obs_busy_cycles !== 4) begin
         tests_failed++;
         $display("[TB] FAIL write_busy_len: got %0d cycles, expected 4", obs_busy_cycles);
      end
      tests_run++;
      if (obs_ready_pulses !== 0 || obs_ready_next !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL write_no_ready: got %0d pulses (next=%b), expected 0", obs_ready_pulses, obs_ready_next);
      end
      expected_q.push_back(model_mem[idx(1'b0, 24'h000002)]);
      applyStimulus(1'b0, 1'b0, 24'h000002, 8'h00, 1'b0);
      tests_run++;
      if (obs_busy_cycles !== 4) begin
         tests_failed++;
         $display("[TB] FAIL read_busy_len: got %0d cycles, expected 4", obs_busy_cycles);
      end
      tests_run++;
      if (obs_ready_at_fall !== 1'b1 || obs_ready_pulses !== 1 || obs_ready_next !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL read_ready_pulse: at_fall=%b pulses=%0d next=%b, expected 1 1 0", obs_ready_at_fall, obs_ready_pulses, obs_ready_next);
      end
      exp = expected_q.pop_front();
      tests_run++;
      if (obs_data !== exp) begin
         tests_failed++;
         $display("[TB] FAIL read_data: got %h, expected %h", obs_data, exp);
      end
   endtask

   task automatic test_bank_alias;
      logic [23:0] rd_addr [3] = '{24'h000005, 24'h000005, 24'h001005};
      logic        rd_bank [3] = '{1'b0, 1'b1, 1'b0};
      logic [7:0]  exp;
      applyStimulus(1'b1, 1'b0, 24'h000005, 8'h11, 1'b0);
      model_mem[idx(1'b0, 24'h000005)] = 8'h11;
      applyStimulus(1'b1, 1'b1, 24'h000005, 8'h22, 1'b0);
      model_mem[idx(1'b1, 24'h000005)] = 8'h22;
      for (int i = 0; i < 3; i++) begin
         expected_q.push_back(model_mem[idx(rd_bank[i], rd_addr[i])]);
         applyStimulus(1'b0, rd_bank[i], rd_addr[i], 8'h00, 1'b0);
         tests_run++;
         if (obs_ready_at_fall !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL alias_ready[%0d]: ready at busy fall=%b, expected 1", i, obs_ready_at_fall);
         end
         exp = expected_q.pop_front();
         tests_run++;
         if (obs_data !== exp) begin
            tests_failed++;
            $display("[TB] FAIL alias_data[%0d]: bank %b addr %h got %h, expected %h", i, rd_bank[i], rd_addr[i], obs_data, exp);
         end
      end
   endtask

   task automatic test_back_to_back;
      int         pulses;
      logic       exp_busy;
      logic [7:0] exp;
      pulses = 0;
      repeat (3) expected_q.push_back(model_mem[idx(1'b0, 24'h000002)]);
      bus.i_cs      = 1'b0;
      bus.i_write   = 1'b0;
      bus.i_bank    = 1'b0;
      bus.i_address = 24'h000002;
      for (int c = 1; c <= 17; c++) begin
         tick;
         if (c == 11) bus.i_cs = 1'b1;
         exp_busy = (c <= 15) && ((c % 5) != 0);
         tests_run++;
         if (bus.o_busy !== exp_busy) begin
            tests_failed++;
            $display("[TB] FAIL b2b_busy[%0d]: got %b, expected %b", c, bus.o_busy, exp_busy);
         end
         if (bus.o_dataReady === 1'b1) begin
            pulses++;
            tests_run++;
            if (expected_q.size() == 0) begin
               tests_failed++;
               $display("[TB] FAIL b2b_extra_ready[%0d]: got unexpected pulse, expected none", c);
            end else begin
               exp = expected_q.pop_front();
               if (bus.o_dataRead !== exp) begin
                  tests_failed++;
                  $display("[TB] FAIL b2b_data[%0d]: got %h, expected %h", c, bus.o_dataRead, exp);
               end
            end
         end
      end
      tests_run++;
      if (pulses !== 3) begin
         tests_failed++;
         $display("[TB] FAIL b2b_pulses: got %0d, expected 3", pulses);
      end
      expected_q.delete();
   endtask

   task automatic test_ignore_busy;
      logic [7:0] exp;
      applyStimulus(1'b1, 1'b0, 24'h000007, 8'h3C, 1'b0);
      model_mem[idx(1'b0, 24'h000007)] = 8'h3C;
      expected_q.push_back(model_mem[idx(1'b0, 24'h000002)]);
      applyStimulus(1'b0, 1'b0, 24'h000002, 8'h00, 1'b1);
      tests_run++;
      if (obs_busy_cycles !== 4) begin
         tests_failed++;
         $display("[TB] FAIL ignore_busy_len: got %0d cycles, expected 4", obs_busy_cycles);
      end
      exp = expected_q.pop_front();
      tests_run++;
      if (obs_data !== exp || obs_ready_at_fall !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL ignore_read: got %h (ready=%b), expected %h (ready=1)", obs_data, obs_ready_at_fall, exp);
      end
      expected_q.push_back(model_mem[idx(1'b0, 24'h000007)]);
      applyStimulus(1'b0, 1'b0, 24'h000007, 8'h00, 1'b0);
      exp = expected_q.pop_front();
      tests_run++;
      if (obs_data !== exp) begin
         tests_failed++;
         $display("[TB] FAIL ignore_array: array[7] got %h, expected %h", obs_data, exp);
      end
   endtask

   task automatic test_reset_abort;
      int         n;
      logic       saw_ready;
      logic [7:0] exp;
      saw_ready         = 1'b0;
      bus.i_cs          = 1'b0;
      bus.i_write       = 1'b1;
      bus.i_bank        = 1'b0;
      bus.i_address     = 24'h000002;
      bus.i_dataToWrite = 8'h99;
      tick;
      bus.i_cs = 1'b1;
      tests_run++;
      if (bus.o_busy !== 1'b1 || bus.o_state !== 3'd2) begin
         tests_failed++;
         $display("[TB] FAIL abort_accept: busy=%b state=%0d, expected busy=1 state=2", bus.o_busy, bus.o_state);
      end
      repeat (2) begin
         tick;
         if (bus.o_dataReady === 1'b1) saw_ready = 1'b1;
      end
      rst = 1'b1;
      repeat (2) begin
         tick;
         if (bus.o_dataReady === 1'b1) saw_ready = 1'b1;
      end
      tests_run++;
      if (bus.o_state !== 3'd0 || bus.o_dataRead !== 8'h00) begin
         tests_failed++;
         $display("[TB] FAIL abort_reset: state=%0d data=%h, expected state=0 data=00", bus.o_state, bus.o_dataRead);
      end
      rst = 1'b0;
      n = 0;
      while (bus.o_state !== 3'd1 && n < 40) begin
         tick;
         n++;
         if (bus.o_dataReady === 1'b1) saw_ready = 1'b1;
      end
      tests_run++;
      if (n !== 8 || saw_ready !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL abort_reinit: edges=%0d ready_seen=%b, expected 8 and 0", n, saw_ready);
      end
      expected_q.push_back(model_mem[idx(1'b0, 24'h000002)]);
      applyStimulus(1'b0, 1'b0, 24'h000002, 8'h00, 1'b0);
      exp = expected_q.pop_front();
      tests_run++;
      if (obs_data !== exp || obs_ready_at_fall !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL abort_data: got %h (ready=%b), expected %h (ready=1)", obs_data, obs_ready_at_fall, exp);
      end
   endtask

   // Main sequence
   initial begin
      rst               = 1'b1;
      bus.i_cs          = 1'b1;
      bus.i_write       = 1'b0;
      bus.i_address     = 24'h000000;
      bus.i_bank        = 1'b0;
      bus.i_dataToWrite = 8'h00;
      #1;
      test_reset;
      test_write_read;
      test_bank_alias;
      test_back_to_back;
      test_ignore_busy;
      test_reset_abort;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   // Safety net so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
